// File: rtl/systolic_result_drain_4x4.sv
// Result drain for the 4x4 systolic array: captures four result rows into a
// 4x4 buffer, then streams the 16 elements over a valid/ready interface.
module systolic_result_drain_4x4 #(
  parameter int DATA_WIDTH = 16,
  parameter bit COL_MAJOR  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    result_ld,
  input  logic [2*DATA_WIDTH-1:0] sa_GD0,
  input  logic [2*DATA_WIDTH-1:0] sa_GD1,
  input  logic [2*DATA_WIDTH-1:0] sa_GD2,
  input  logic [2*DATA_WIDTH-1:0] sa_GD3,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [1:0]              out_row,
  output logic [1:0]              out_col,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overflow
);

  localparam int DW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_buf [16];
  logic [1:0]    r_row;
  logic [3:0]    r_idx;
  logic          r_overflow;
  logic          w_wr;
  logic [1:0]    w_wr_row;
  logic          w_xfer;
  logic [1:0]    w_rd_row;
  logic [1:0]    w_rd_col;

  assign w_xfer = (r_state == S_DRAIN) && out_ready;

  always_comb begin
    w_next   = r_state;
    w_wr     = 1'b0;
    w_wr_row = r_row;
    unique case (r_state)
      S_IDLE: begin
        if (result_ld) begin
          w_next   = S_CAPTURE;
          w_wr     = 1'b1;
          w_wr_row = 2'd0;
        end
      end
      S_CAPTURE: begin
        w_wr = 1'b1;
        if (r_row == 2'd3) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready && (r_idx == 4'd15)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= 2'd0;
      r_idx      <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wr) begin
        r_row <= w_wr_row + 2'd1;
      end
      if (r_state == S_IDLE) begin
        r_idx <= 4'd0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 4'd1;
      end
      // A start request can only be honoured from IDLE; anything else is lost.
      if (result_ld && (r_state != S_IDLE)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      r_buf[{w_wr_row, 2'd0}] <= sa_GD0;
      r_buf[{w_wr_row, 2'd1}] <= sa_GD1;
      r_buf[{w_wr_row, 2'd2}] <= sa_GD2;
      r_buf[{w_wr_row, 2'd3}] <= sa_GD3;
    end
  end

  assign w_rd_row = COL_MAJOR ? r_idx[1:0] : r_idx[3:2];
  assign w_rd_col = COL_MAJOR ? r_idx[3:2] : r_idx[1:0];

  assign out_valid = (r_state == S_DRAIN);
  assign out_data  = out_valid ? r_buf[{w_rd_row, w_rd_col}] : '0;
  assign out_row   = out_valid ? w_rd_row : 2'd0;
  assign out_col   = out_valid ? w_rd_col : 2'd0;
  assign out_last  = out_valid && (r_idx == 4'd15);
  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_systolic_result_drain_4x4.sv
// Bench for systolic_result_drain_4x4: row- and column-major instances share
// stimulus and are checked against a matrix/order reference model.
module tb_systolic_result_drain_4x4;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          result_ld;
  logic          out_ready;
  logic [DW-1:0] gd [4];

  logic          v0, v1, l0, l1, b0, b1, o0, o1;
  logic [DW-1:0] d0, d1;
  logic [1:0]    r0, c0, r1, c1;

  always #5 clk = ~clk;

  systolic_result_drain_4x4 #(.DATA_WIDTH(16), .COL_MAJOR(1'b0)) u_row (
    .clk(clk), .rst(rst), .result_ld(result_ld),
    .sa_GD0(gd[0]), .sa_GD1(gd[1]), .sa_GD2(gd[2]), .sa_GD3(gd[3]),
    .out_ready(out_ready), .out_valid(v0), .out_data(d0),
    .out_row(r0), .out_col(c0), .out_last(l0),
    .busy(b0), .overflow(o0)
  );

  systolic_result_drain_4x4 #(.DATA_WIDTH(16), .COL_MAJOR(1'b1)) u_col (
    .clk(clk), .rst(rst), .result_ld(result_ld),
    .sa_GD0(gd[0]), .sa_GD1(gd[1]), .sa_GD2(gd[2]), .sa_GD3(gd[3]),
    .out_ready(out_ready), .out_valid(v1), .out_data(d1),
    .out_row(r1), .out_col(c1), .out_last(l1),
    .busy(b1), .overflow(o1)
  );

  typedef struct {
    int mode;
    int rdy;
    int ld_at;
    int rst_at;
    bit ovf;
  } vec_t;

  vec_t          tbl [9];
  logic [DW-1:0] mat [16];
  bit            exp_ovf;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".valid0"}, 64'(v0), 64'd0);
    chk({nm, ".valid1"}, 64'(v1), 64'd0);
    chk({nm, ".busy0"}, 64'(b0), 64'd0);
    chk({nm, ".busy1"}, 64'(b1), 64'd0);
    chk({nm, ".data0"}, 64'(d0), 64'd0);
    chk({nm, ".data1"}, 64'(d1), 64'd0);
    chk({nm, ".rc0"}, 64'({r0, c0, l0}), 64'd0);
    chk({nm, ".rc1"}, 64'({r1, c1, l1}), 64'd0);
    chk({nm, ".ovf0"}, 64'(o0), 64'(exp_ovf));
    chk({nm, ".ovf1"}, 64'(o1), 64'(exp_ovf));
  endtask

  // Element k of the stream: row-major visits mat[k], column-major transposes.
  task automatic chk_elem(input int k);
    int rr, cc;
    rr = k / 4;
    cc = k % 4;
    chk($sformatf("valid0[%0d]", k), 64'(v0), 64'd1);
    chk($sformatf("data0[%0d]", k), 64'(d0), 64'(mat[rr*4+cc]));
    chk($sformatf("rc0[%0d]", k), 64'({r0, c0}), 64'(rr*4+cc));
    chk($sformatf("last0[%0d]", k), 64'(l0), 64'(k == 15));
    rr = k % 4;
    cc = k / 4;
    chk($sformatf("valid1[%0d]", k), 64'(v1), 64'd1);
    chk($sformatf("data1[%0d]", k), 64'(d1), 64'(mat[rr*4+cc]));
    chk($sformatf("rc1[%0d]", k), 64'({r1, c1}), 64'(rr*4+cc));
    chk($sformatf("last1[%0d]", k), 64'(l1), 64'(k == 15));
    chk($sformatf("busy[%0d]", k), 64'({b0, b1}), 64'h3);
    chk($sformatf("ovf[%0d]", k), 64'({o0, o1}), exp_ovf ? 64'h3 : 64'h0);
  endtask

  task automatic fill_mat(input int mode);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       mat[i] = 32'(16 * (i / 4) + (i % 4));
        1:       mat[i] = ((i + i / 4) % 2 == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
        default: mat[i] = $urandom;
      endcase
    end
  endtask

  task automatic set_row(input int r);
    for (int c = 0; c < 4; c++) gd[c] = mat[r*4+c];
  endtask

  task automatic run_vec(input vec_t v, input bit from_tbl);
    int k, cyc;
    bit rdy, ldd, pend, done;
    fill_mat(v.mode);
    result_ld = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    set_row(0);
    @(negedge clk);
    result_ld = 1'b0;
    for (int r = 1; r < 4; r++) begin
      chk($sformatf("cap_busy[%0d]", r), 64'({b0, b1}), 64'h3);
      chk($sformatf("cap_valid[%0d]", r), 64'({v0, v1}), 64'h0);
      set_row(r);
      @(negedge clk);
    end
    k = 0;
    cyc = 0;
    ldd = 1'b0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      chk_elem(k);
      if (k == v.rst_at) begin
        rst = 1'b1;
        result_ld = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        result_ld = 1'b0;
        exp_ovf = 1'b0;
        chk_idle("after_rst");
        @(negedge clk);
        chk_idle("rst_ld_ignored");
        return;
      end
      case (v.rdy)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pend = (k == v.ld_at) && !ldd;
      if (pend) ldd = 1'b1;
      result_ld = pend;
      out_ready = rdy;
      for (int c = 0; c < 4; c++) gd[c] = $urandom;
      @(negedge clk);
      result_ld = 1'b0;
      if (pend) exp_ovf = 1'b1;
      if (rdy) begin
        k++;
        if (k == 16) done = 1'b1;
      end
      cyc++;
    end
    chk("drain_done", 64'(done), 64'd1);
    chk_idle("end");
    if (from_tbl) chk("tbl_ovf", 64'({o0, o1}), v.ovf ? 64'h3 : 64'h0);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t rv;
    tbl[0] = '{mode: 0, rdy: 0, ld_at: -1, rst_at: -1, ovf: 1'b0};
    tbl[1] = '{mode: 1, rdy: 0, ld_at: -1, rst_at: -1, ovf: 1'b0};
    tbl[2] = '{mode: 2, rdy: 1, ld_at: -1, rst_at: -1, ovf: 1'b0};
    tbl[3] = '{mode: 0, rdy: 0, ld_at: 5,  rst_at: -1, ovf: 1'b1};
    tbl[4] = '{mode: 2, rdy: 2, ld_at: -1, rst_at: -1, ovf: 1'b1};
    tbl[5] = '{mode: 0, rdy: 0, ld_at: -1, rst_at: 7,  ovf: 1'b0};
    tbl[6] = '{mode: 0, rdy: 0, ld_at: -1, rst_at: -1, ovf: 1'b0};
    tbl[7] = '{mode: 1, rdy: 0, ld_at: 15, rst_at: -1, ovf: 1'b1};
    tbl[8] = '{mode: 0, rdy: 1, ld_at: 2,  rst_at: -1, ovf: 1'b1};

    rst = 1'b1;
    result_ld = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) gd[c] = $urandom;
    exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b0;
    result_ld = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    for (int i = 0; i < 9; i++) run_vec(tbl[i], 1'b1);

    for (int i = 0; i < 6; i++) begin
      rv.mode = 2;
      rv.rdy = 2;
      rv.ld_at = $urandom_range(0, 24);
      rv.rst_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      rv.ovf = 1'b0;
      run_vec(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
